// File: rtl/layer_sequencer_if.sv
// Handshake and layer-side bus of the layer sequencer.
// master: the sequencer itself; slave: the upstream/downstream/layer environment.
interface layer_sequencer_if #(
    parameter int NUM_INPUT  = 30,
    parameter int NUM_NEURON = 10,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_INPUT*DATA_WIDTH-1:0]  i_vec;
    logic                             i_vec_valid;
    logic                             o_vec_ready;
    logic [DATA_WIDTH-1:0]            o_layer_input;
    logic                             o_layer_input_valid;
    logic [NUM_NEURON-1:0]            i_layer_input_ready;
    logic [NUM_NEURON*DATA_WIDTH-1:0] i_layer_output;
    logic [NUM_NEURON-1:0]            i_layer_output_valid;
    logic [NUM_NEURON*DATA_WIDTH-1:0] o_vec;
    logic                             o_vec_valid;
    logic                             i_vec_ready;
    logic                             o_busy;
    logic                             o_err;

    modport master (
        input  i_vec, i_vec_valid, i_layer_input_ready, i_layer_output,
               i_layer_output_valid, i_vec_ready,
        output o_vec_ready, o_layer_input, o_layer_input_valid, o_vec,
               o_vec_valid, o_busy, o_err
    );

    modport slave (
        output i_vec, i_vec_valid, i_layer_input_ready, i_layer_output,
               i_layer_output_valid, i_vec_ready,
        input  o_vec_ready, o_layer_input, o_layer_input_valid, o_vec,
               o_vec_valid, o_busy, o_err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Streams a buffered input vector element by element into a fully-connected layer and
// gathers the per-neuron output pulses into a result vector for the next stage.
module layer_sequencer #(
    parameter int NUM_INPUT  = 30,
    parameter int NUM_NEURON = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    layer_sequencer_if.master  bus
);
    localparam int VW    = NUM_INPUT * DATA_WIDTH;
    localparam int RW    = NUM_NEURON * DATA_WIDTH;
    localparam int IDX_W = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_NEURON-1:0]   done_q, done_d;
    logic [VW-1:0]           shadow_q, shadow_d;
    logic [RW-1:0]           vec_q, vec_d;
    logic [DATA_WIDTH-1:0]   elem_q, elem_d;
    logic                    err_q, err_d;

    logic                    all_ready;
    logic                    fire;
    logic                    last_elem;
    logic                    capturing;
    logic                    all_done;
    logic [NUM_NEURON-1:0]   new_cap;
    logic [NUM_NEURON-1:0]   dup_hit;
    logic [DATA_WIDTH-1:0]   next_elem;

    assign all_ready = &bus.i_layer_input_ready;
    assign fire      = (state_q == SEND) && all_ready;
    assign last_elem = (idx_q == LAST_IDX);
    assign capturing = (state_q == SEND) || (state_q == WAIT);
    assign new_cap   = capturing ? (bus.i_layer_output_valid & ~done_q) : '0;
    assign dup_hit   = capturing ? (bus.i_layer_output_valid & done_q) : '0;
    assign all_done  = &(done_q | new_cap);

    // Element idx+1 is preloaded into elem_q so the layer input stays a registered path.
    always_comb begin
        next_elem = '0;
        for (int unsigned k = 1; k < NUM_INPUT; k++) begin
            if (k == 32'(idx_q) + 32'd1) begin
                next_elem = shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        elem_d   = elem_q;
        err_d    = err_q;
        done_d   = done_q | new_cap;
        vec_d    = vec_q;

        for (int unsigned n = 0; n < NUM_NEURON; n++) begin
            if (new_cap[n]) begin
                vec_d[n*DATA_WIDTH +: DATA_WIDTH] = bus.i_layer_output[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Repeated pulses keep the first value; pulses outside SEND/WAIT are dropped.
        if (|dup_hit) begin
            err_d = 1'b1;
        end
        if (!capturing && (|bus.i_layer_output_valid)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_vec_valid) begin
                    shadow_d = bus.i_vec;
                    elem_d   = bus.i_vec[DATA_WIDTH-1:0];
                    idx_d    = '0;
                    done_d   = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    if (last_elem) begin
                        state_d = WAIT;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        elem_d = next_elem;
                    end
                end
                // Every neuron answered while elements were still pending.
                if (all_done && !(fire && last_elem)) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (all_done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.i_vec_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            done_q   <= '0;
            shadow_q <= '0;
            vec_q    <= '0;
            elem_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            vec_q    <= vec_d;
            elem_q   <= elem_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_vec_ready         = (state_q == IDLE);
    assign bus.o_layer_input       = elem_q;
    assign bus.o_layer_input_valid = fire;
    assign bus.o_vec               = vec_q;
    assign bus.o_vec_valid         = (state_q == OUT);
    assign bus.o_busy              = (state_q != IDLE);
    assign bus.o_err               = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized self-checking bench for layer_sequencer against a queue-based reference model.
module tb_layer_sequencer;
    localparam int NI     = 4;
    localparam int NN     = 3;
    localparam int DW     = 16;
    localparam int VW     = NI * DW;
    localparam int RW     = NN * DW;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_sequencer_if #(.NUM_INPUT(NI), .NUM_NEURON(NN), .DATA_WIDTH(DW)) bus ();

    layer_sequencer #(.NUM_INPUT(NI), .NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: sticky error flag and the result slot value per neuron.
    logic          err_m;
    logic [DW-1:0] res_m [NN];

    function automatic logic [RW-1:0] packed_res();
        logic [RW-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) r[n*DW +: DW] = res_m[n];
        return r;
    endfunction

    task automatic clear_inputs();
        bus.i_vec                = '0;
        bus.i_vec_valid          = 1'b0;
        bus.i_vec_ready          = 1'b0;
        bus.i_layer_input_ready  = '0;
        bus.i_layer_output       = '0;
        bus.i_layer_output_valid = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        for (int n = 0; n < NN; n++) res_m[n] = '0;
    endtask

    // One full vector transaction; pN = cycle (after accept) at which neuron N pulses.
    task automatic run_vector(
        input  logic [VW-1:0] vec,
        input  logic [RW-1:0] vals,
        input  int p0, input int p1, input int p2, input int dup_at,
        input  int stall_pct, input int stall_n, input int stall_from, input int stall_len,
        input  int hold, input bit junk,
        output int obs_last, output int obs_out);
        logic [DW-1:0] q[$];
        bit            done [NN];
        int            pa   [NN];
        int            exp_out;
        logic [NN-1:0] rdy, pv;
        logic [RW-1:0] pval, expv;
        bit            in_wait, exp_v, all_done, exp_vv;
        pa[0] = p0; pa[1] = p1; pa[2] = p2;
        obs_last = -1; obs_out = -1; exp_out = -1;

        bus.i_vec = vec; bus.i_vec_valid = 1'b1; bus.i_vec_ready = 1'b0;
        bus.i_layer_output_valid = '0; bus.i_layer_input_ready = '1;
        #1;
        checks++; if (bus.o_vec_ready !== 1'b1) begin errors++; $display("FAIL idle_vec_ready: got %b exp 1", bus.o_vec_ready); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", bus.o_busy); end
        checks++; if (bus.o_err !== err_m) begin errors++; $display("FAIL idle_err: got %b exp %b", bus.o_err, err_m); end
        @(negedge clk);
        for (int i = 0; i < NI; i++) q.push_back(vec[i*DW +: DW]);
        for (int n = 0; n < NN; n++) done[n] = 1'b0;
        bus.i_vec_valid = 1'b0;

        for (int k = 1; k <= BUDGET; k++) begin
            rdy = '1;
            for (int n = 0; n < NN; n++) if (int'($urandom_range(99)) < stall_pct) rdy[n] = 1'b0;
            if (stall_n >= 0 && k >= stall_from && k < stall_from + stall_len) rdy[stall_n] = 1'b0;
            pv = '0;
            pval = RW'({$urandom(), $urandom()});
            for (int n = 0; n < NN; n++) if (pa[n] == k) begin pv[n] = 1'b1; pval[n*DW +: DW] = vals[n*DW +: DW]; end
            if (dup_at == k) begin pv[0] = 1'b1; pval[DW-1:0] = 16'h0FFF; end
            bus.i_layer_input_ready = rdy; bus.i_layer_output_valid = pv; bus.i_layer_output = pval;
            if (junk) begin bus.i_vec_valid = 1'($urandom_range(1)); bus.i_vec = VW'({$urandom(), $urandom()}); end
            #1;
            exp_vv = (k == exp_out);
            checks++; if (bus.o_vec_valid !== exp_vv) begin errors++; $display("FAIL vec_valid_timing: cycle %0d got %b exp %b", k, bus.o_vec_valid, exp_vv); end
            if (bus.o_vec_valid === 1'b1) begin obs_out = k; bus.i_layer_output_valid = '0; break; end
            in_wait = (q.size() == 0);
            exp_v = !in_wait && (&rdy);
            checks++; if (bus.o_layer_input_valid !== exp_v) begin errors++; $display("FAIL input_valid: cycle %0d got %b exp %b", k, bus.o_layer_input_valid, exp_v); end
            if (!in_wait) begin
                checks++; if (bus.o_layer_input !== q[0]) begin errors++; $display("FAIL input_data: cycle %0d got %h exp %h", k, bus.o_layer_input, q[0]); end
            end
            checks++; if (bus.o_busy !== 1'b1 || bus.o_vec_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: cycle %0d got busy=%b ready=%b exp 1/0", k, bus.o_busy, bus.o_vec_ready); end
            checks++; if (bus.o_err !== err_m) begin errors++; $display("FAIL err_flag: cycle %0d got %b exp %b", k, bus.o_err, err_m); end
            if (bus.o_layer_input_valid === 1'b1) obs_last = k;
            if (exp_v) void'(q.pop_front());
            for (int n = 0; n < NN; n++) begin
                if (pv[n]) begin
                    if (done[n]) err_m = 1'b1;
                    else begin done[n] = 1'b1; res_m[n] = pval[n*DW +: DW]; end
                end
            end
            all_done = 1'b1;
            for (int n = 0; n < NN; n++) if (!done[n]) all_done = 1'b0;
            if (all_done && q.size() != 0) err_m = 1'b1;
            if (all_done && in_wait && exp_out < 0) exp_out = k + 1;
            @(negedge clk);
        end

        if (obs_out < 0) begin
            checks++; errors++;
            $display("FAIL out_timeout: o_vec_valid never rose within %0d cycles, exp at cycle %0d", BUDGET, exp_out);
            bus.i_vec_valid = 1'b0;
            return;
        end

        expv = packed_res();
        for (int h = 0; h <= hold; h++) begin
            bus.i_layer_output_valid = '0;
            bus.i_vec_ready = (h == hold);
            if (junk) begin bus.i_vec_valid = 1'b1; bus.i_vec = VW'({$urandom(), $urandom()}); end
            #1;
            checks++; if (bus.o_vec_valid !== 1'b1) begin errors++; $display("FAIL out_valid: hold %0d got %b exp 1", h, bus.o_vec_valid); end
            checks++; if (bus.o_vec !== expv) begin errors++; $display("FAIL out_vec: hold %0d got %h exp %h", h, bus.o_vec, expv); end
            checks++; if (bus.o_vec_ready !== 1'b0 || bus.o_layer_input_valid !== 1'b0) begin errors++; $display("FAIL out_quiet: got ready=%b ivalid=%b exp 0/0", bus.o_vec_ready, bus.o_layer_input_valid); end
            checks++; if (bus.o_err !== err_m) begin errors++; $display("FAIL out_err: got %b exp %b", bus.o_err, err_m); end
            @(negedge clk);
        end

        bus.i_vec_ready = 1'b0; bus.i_vec_valid = 1'b0; bus.i_layer_input_ready = '1;
        #1;
        checks++; if (bus.o_vec_valid !== 1'b0 || bus.o_vec_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL back_to_idle: got valid=%b ready=%b busy=%b exp 0/1/0", bus.o_vec_valid, bus.o_vec_ready, bus.o_busy); end
        checks++; if (bus.o_vec !== expv) begin errors++; $display("FAIL idle_retain: got %h exp %h", bus.o_vec, expv); end
        checks++; if (bus.o_layer_input_valid !== 1'b0) begin errors++; $display("FAIL idle_ivalid: got %b exp 0", bus.o_layer_input_valid); end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (bus.o_vec_ready !== 1'b1) begin errors++; $display("FAIL rst_vec_ready: got %b exp 1", bus.o_vec_ready); end
        checks++; if (bus.o_layer_input_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid: got %b exp 0", bus.o_layer_input_valid); end
        checks++; if (bus.o_layer_input !== 16'h0000) begin errors++; $display("FAIL rst_input: got %h exp 0000", bus.o_layer_input); end
        checks++; if (bus.o_vec !== 48'h0) begin errors++; $display("FAIL rst_vec: got %h exp 0", bus.o_vec); end
        checks++; if (bus.o_vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vec_valid: got %b exp 0", bus.o_vec_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.o_busy); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", bus.o_err); end
    endtask

    task automatic test_basic();
        int ls, oc;
        apply_reset();
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 5, 5, 5, -1, 0, -1, 0, 0, 0, 0, ls, oc);
        checks++; if (ls !== 4) begin errors++; $display("FAIL basic_last_send: got %0d exp 4", ls); end
        checks++; if (oc !== 6) begin errors++; $display("FAIL basic_out_cycle: got %0d exp 6", oc); end
        checks++; if (bus.o_vec !== 48'h00C0_00B0_00A0) begin errors++; $display("FAIL basic_vec: got %h exp 00c000b000a0", bus.o_vec); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", bus.o_err); end
    endtask

    task automatic test_stall();
        int ls, oc;
        apply_reset();
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 9, 9, 9, -1, 0, 1, 3, 3, 0, 0, ls, oc);
        checks++; if (ls !== 7) begin errors++; $display("FAIL stall_last_send: got %0d exp 7", ls); end
        checks++; if (oc !== 10) begin errors++; $display("FAIL stall_out_cycle: got %0d exp 10", oc); end
    endtask

    task automatic test_split_capture();
        int ls, oc;
        apply_reset();
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 7, 7, 5, -1, 0, -1, 0, 0, 0, 0, ls, oc);
        checks++; if (oc !== 8) begin errors++; $display("FAIL split_out_cycle: got %0d exp 8", oc); end
        checks++; if (bus.o_vec !== 48'h00C0_00B0_00A0) begin errors++; $display("FAIL split_vec: got %h exp 00c000b000a0", bus.o_vec); end
    endtask

    task automatic test_errors();
        int ls, oc;
        logic [RW-1:0] v;
        apply_reset();
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 5, 7, 7, 6, 0, -1, 0, 0, 0, 0, ls, oc);
        v = bus.o_vec;
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL dup_err: got %b exp 1", bus.o_err); end
        checks++; if (v[DW-1:0] !== 16'h00A0) begin errors++; $display("FAIL dup_keep_first: got %h exp 00a0", v[DW-1:0]); end

        apply_reset();
        bus.i_layer_output_valid = 3'b010; bus.i_layer_output = 48'h1234_5678_9ABC;
        #1;
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL stray_err_pre: got %b exp 0", bus.o_err); end
        @(negedge clk);
        bus.i_layer_output_valid = '0;
        #1;
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b exp 1", bus.o_err); end
        checks++; if (bus.o_vec !== 48'h0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL stray_ignored: got vec=%h busy=%b exp 0/0", bus.o_vec, bus.o_busy); end

        apply_reset();
        run_vector(64'h0044_0033_0022_0011, 48'h0003_0002_0001, 1, 2, 3, -1, 0, -1, 0, 0, 0, 0, ls, oc);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL early_done_err: got %b exp 1", bus.o_err); end
        checks++; if (oc !== 6) begin errors++; $display("FAIL early_done_out: got %0d exp 6", oc); end
    endtask

    task automatic test_out_hold();
        int ls, oc;
        apply_reset();
        run_vector(64'hBEEF_0BAD_F00D_CAFE, 48'h0C0C_0B0B_0A0A, 6, 5, 6, -1, 0, -1, 0, 0, 5, 1, ls, oc);
        checks++; if (bus.o_vec !== 48'h0C0C_0B0B_0A0A) begin errors++; $display("FAIL hold_vec: got %h exp 0c0c0b0b0a0a", bus.o_vec); end
    endtask

    task automatic test_back_to_back();
        int ls, oc;
        apply_reset();
        for (int t = 0; t < 3; t++) begin
            run_vector(VW'({$urandom(), $urandom()}), RW'({$urandom(), $urandom()}),
                       5, 5 + t, 6, -1, 0, -1, 0, 0, 0, 0, ls, oc);
            checks++; if (ls !== 4) begin errors++; $display("FAIL b2b_last_send: vec %0d got %0d exp 4", t, ls); end
        end
    endtask

    task automatic test_random();
        int ls, oc;
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            run_vector(VW'({$urandom(), $urandom()}), RW'({$urandom(), $urandom()}),
                       1 + int'($urandom_range(NI + 5)), 1 + int'($urandom_range(NI + 5)),
                       1 + int'($urandom_range(NI + 5)), -1, 30, -1, 0, 0,
                       int'($urandom_range(3)), bit'($urandom_range(1)), ls, oc);
        end
    endtask

    task automatic test_reset_midsend();
        int ls, oc;
        apply_reset();
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 5, 5, 5, -1, 0, -1, 0, 0, 0, 0, ls, oc);
        @(negedge clk);
        bus.i_layer_output_valid = 3'b001;
        @(negedge clk);
        bus.i_layer_output_valid = '0;
        bus.i_vec = 64'h0008_0007_0006_0005; bus.i_vec_valid = 1'b1;
        @(negedge clk);
        bus.i_vec_valid = 1'b0; bus.i_layer_input_ready = '1;
        #1;
        checks++; if (bus.o_layer_input_valid !== 1'b1 || bus.o_err !== 1'b1) begin errors++; $display("FAIL midsend_pre: got ivalid=%b err=%b exp 1/1", bus.o_layer_input_valid, bus.o_err); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.o_layer_input_valid !== 1'b0) begin errors++; $display("FAIL midsend_ivalid: got %b exp 0", bus.o_layer_input_valid); end
        checks++; if (bus.o_vec_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL midsend_idle: got ready=%b busy=%b exp 1/0", bus.o_vec_ready, bus.o_busy); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL midsend_err: got %b exp 0", bus.o_err); end
        checks++; if (bus.o_vec !== 48'h0 || bus.o_layer_input !== 16'h0) begin errors++; $display("FAIL midsend_data: got vec=%h in=%h exp 0/0", bus.o_vec, bus.o_layer_input); end
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        for (int n = 0; n < NN; n++) res_m[n] = '0;
        run_vector(64'h0004_0003_0002_0001, 48'h00C0_00B0_00A0, 6, 6, 6, -1, 0, -1, 0, 0, 0, 0, ls, oc);
        checks++; if (oc !== 7) begin errors++; $display("FAIL post_reset_out: got %0d exp 7", oc); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_split_capture();
        test_errors();
        test_out_hold();
        test_back_to_back();
        test_random();
        test_reset_midsend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
